mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
  clk  in  1  system clock; all state on rising edge
  rst  in  1  reset, asynchronous, active-low
  if_req  in  1  instruction fetch request, held until if_ack
  if_addr  in  32  fetch byte address
  if_ack  out  1  one-cycle pulse; fetch word valid on if_data
  if_data  out  32  fetched word, little-endian
  mem_req  in  1  load/store request, held until mem_ack
  mem_we  in  1  1 = store, 0 = load
  mem_len  in  2  00 byte, 01 half, 11 word; 10 treated as word
  mem_signed  in  1  sign-extend load (see Configuration)
  mem_addr  in  32  load/store byte address
  mem_wdata  in  32  store data, low bytes used
  mem_ack  out  1  one-cycle completion pulse
  mem_rdata  out  32  load result, valid while mem_ack
  ram_addr  out  32  RAM byte address
  ram_wr  out  1  RAM write strobe
  ram_dout  out  8  RAM write byte
  ram_din  in  8  RAM read byte, one cycle after ram_addr
  stallreq_if  out  1  fetch pending, equal to `Stop when active
  stallreq_mem  out  1  load/store pending, equal to `Stop when active

Function
REQ-002 States SHALL be IDLE, RD, WR and DONE.
REQ-003 In IDLE with mem_req=1, the block SHALL accept MEM. MEM has fixed priority over IF.
REQ-004 In IDLE with only if_req=1, the block SHALL accept IF as a 4-byte read.
REQ-005 On acceptance, the block SHALL latch address, length N (1/2/4), direction and wdata; requester inputs are then ignored until ack.
REQ-006 A grant SHALL never be preempted.
REQ-007 Read, counting from accept edge A: ram_addr=base+k in cycle A+1+k (k=0..N-1); byte k captured at edge A+2+k; ack high in cycle A+N+2 (N+2 cycles after accept).
REQ-008 Write: ram_wr=1, ram_addr=base+k and ram_dout=wdata[8k+7:8k] in cycle A+1+k; ack high in cycle A+N+1.
REQ-009 The block SHALL enter DONE for exactly one cycle after ack before returning to IDLE, so a requester dropping req after ack is never re-accepted.
REQ-010 ram_wr SHALL be 0 outside WR. ram_addr SHALL hold its last value when idle.
REQ-011 Address increment SHALL wrap modulo 2^32.
REQ-012 stallreq_x SHALL be `Stop whenever x_req=1 and the cycle is not x's ack cycle; it SHALL be combinational from req and ack.
REQ-013 Read data bytes not covered by N SHALL be zero, unless sign-extended per REQ-018.
REQ-014 if_data and mem_rdata SHALL hold their values after ack until the next completion of that port.

Reset
REQ-015 Asserting rst (low) at any time, including mid-transfer, SHALL immediately force IDLE, if_ack=0, mem_ack=0, ram_wr=0, ram_addr=0, ram_dout=0, if_data=0, mem_rdata=0 and counter=0. Any aborted transfer is discarded without ack.
REQ-016 After rst deasserts, the first acceptance SHALL occur at the first rising edge.

Configuration
REQ-017 Macro MEM_ARB_SIGNEXT_EN SHALL select load extension behaviour.
REQ-018 With MEM_ARB_SIGNEXT_EN defined, byte/half loads with mem_signed=1 SHALL sign-extend from bit 7/15.
REQ-019 Without MEM_ARB_SIGNEXT_EN, mem_signed SHALL be ignored and all loads zero-extended; the port remains present.

Structure
REQ-020 State encoding, mem_len encodings and `Stop/`RstEnable-style constants SHALL live in the shared defines.v.
REQ-021 No sub-module SHALL be used; byte assembly and extension SHALL be inline.

Verification
REQ-022 Fetch: if_req=1, if_addr=0x100, RAM bytes 0x13,0x05,0x00,0x00 -> if_ack exactly 6 cycles after accept, if_data=0x00000513, stallreq_if high until the ack cycle.
REQ-023 Simultaneous: if_req=mem_req=1 in IDLE -> MEM served first. Fetch is accepted after the DONE cycle, and stallreq_if stays high throughout.
REQ-024 Store: mem_we=1, len=01, addr=0x200, wdata=0xDEADBEEF -> ram_wr in 2 cycles with bytes 0xEF then 0xBE at 0x200/0x201, and mem_ack 3 cycles after accept.
REQ-025 Load: byte 0x80, mem_signed=1 -> 0xFFFFFF80 with MEM_ARB_SIGNEXT_EN defined, 0x00000080 without.
REQ-026 Wrap: word read at 0xFFFFFFFE -> ram_addr sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
REQ-027 Reset during the second byte of a word store -> ram_wr=0 and state IDLE immediately, no ack; a new request after release completes normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared state encoding, mem_len codes and stall constants for mem_arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b11;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Code 2'b10 is not a real size; it is served as a word.
  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      LEN_WORD: return 3'd4;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-serial RAM arbiter: load/store port has fixed priority over instruction fetch.
// Define MEM_ARB_SIGNEXT_EN to honour mem_signed on byte/half loads.
//   state | meaning
//   IDLE  | waiting; accepts MEM first, then IF
//   RD    | issuing read addresses and capturing returned bytes
//   WR    | driving one write byte per cycle
//   DONE  | ack cycle; always returns to IDLE
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_data,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_len,
  input  logic        mem_signed,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ack,
  output logic [31:0] mem_rdata,
  output logic [31:0] ram_addr,
  output logic        ram_wr,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din,
  output logic        stallreq_if,
  output logic        stallreq_mem
);

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [2:0]  n_q;
  logic        is_mem_q;
  logic [31:0] wdata_q;
  logic [31:0] rbuf_q;
  logic [31:0] rbuf_d;
  logic [31:0] load_d;
  logic [1:0]  rd_idx;
  logic [1:0]  wr_idx;
  logic        if_ack_q;
  logic        mem_ack_q;
  logic [31:0] if_data_q;
  logic [31:0] mem_rdata_q;
  logic [31:0] ram_addr_q;
  logic        ram_wr_q;
  logic [7:0]  ram_dout_q;

`ifdef MEM_ARB_SIGNEXT_EN
  logic        sgn_q;
`else
  logic        unused_signed;
  assign unused_signed = mem_signed;
`endif

  // In RD, count k>0 means byte k-1 is on ram_din this cycle.
  assign rd_idx = cnt_q[1:0] - 2'd1;
  assign wr_idx = cnt_q[1:0] + 2'd1;

  always_comb begin
    rbuf_d = rbuf_q;
    rbuf_d[{rd_idx, 3'b000} +: 8] = ram_din;
  end

  always_comb begin
    load_d = rbuf_d;
`ifdef MEM_ARB_SIGNEXT_EN
    if (sgn_q && n_q == 3'd1) begin
      load_d = {{24{rbuf_d[7]}}, rbuf_d[7:0]};
    end else if (sgn_q && n_q == 3'd2) begin
      load_d = {{16{rbuf_d[15]}}, rbuf_d[15:0]};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      n_q         <= '0;
      is_mem_q    <= 1'b0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= '0;
`ifdef MEM_ARB_SIGNEXT_EN
      sgn_q       <= 1'b0;
`endif
    end else begin
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          rbuf_q <= '0;
          if (mem_req) begin
            is_mem_q   <= 1'b1;
            n_q        <= len_to_n(mem_len);
            wdata_q    <= mem_wdata;
            ram_addr_q <= mem_addr;
`ifdef MEM_ARB_SIGNEXT_EN
            sgn_q      <= mem_signed;
`endif
            if (mem_we) begin
              ram_wr_q   <= 1'b1;
              ram_dout_q <= mem_wdata[7:0];
              state_q    <= WR;
            end else begin
              state_q    <= RD;
            end
          end else if (if_req) begin
            is_mem_q   <= 1'b0;
            n_q        <= 3'd4;
            ram_addr_q <= if_addr;
`ifdef MEM_ARB_SIGNEXT_EN
            sgn_q      <= 1'b0;
`endif
            state_q    <= RD;
          end
        end
        RD: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q != 3'd0) rbuf_q <= rbuf_d;
          if (cnt_q + 3'd1 < n_q) ram_addr_q <= ram_addr_q + 32'd1;
          if (cnt_q == n_q) begin
            cnt_q   <= '0;
            state_q <= DONE;
            if (is_mem_q) begin
              mem_ack_q   <= 1'b1;
              mem_rdata_q <= load_d;
            end else begin
              if_ack_q    <= 1'b1;
              if_data_q   <= rbuf_d;
            end
          end
        end
        WR: begin
          if (cnt_q + 3'd1 < n_q) begin
            cnt_q      <= cnt_q + 3'd1;
            ram_addr_q <= ram_addr_q + 32'd1;
            ram_dout_q <= wdata_q[{wr_idx, 3'b000} +: 8];
          end else begin
            cnt_q     <= '0;
            ram_wr_q  <= 1'b0;
            mem_ack_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_ack    = if_ack_q;
  assign mem_ack   = mem_ack_q;
  assign if_data   = if_data_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wr    = ram_wr_q;
  assign ram_dout  = ram_dout_q;

  assign stallreq_if  = (if_req  && !if_ack_q)  ? STOP : NO_STOP;
  assign stallreq_mem = (mem_req && !mem_ack_q) ? STOP : NO_STOP;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level timing model.
module tb_mem_arbiter;

`ifdef MEM_ARB_SIGNEXT_EN
  localparam bit SEXT_ON = 1'b1;
`else
  localparam bit SEXT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_data;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_len = 2'b00;
  logic        mem_signed = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = 8'h00;
  logic        stallreq_if;
  logic        stallreq_mem;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_signed(mem_signed),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory contents: untouched bytes come from a fixed hash of the address.
  logic [7:0] env_mem [logic [31:0]];
  logic [7:0] mdl_mem [logic [31:0]];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ {a[3:0], a[31:28]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] mdl_rd(input logic [31:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a] : init_byte(a);
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    env_mem[a] = d;
    mdl_mem[a] = d;
  endtask

  always @(posedge clk) begin
    ram_din <= env_rd(ram_addr);
    if (ram_wr) env_mem[ram_addr] = ram_dout;
  end

  // Reference model: a transaction accepted at edge A occupies cycles A+1..A+L
  // (L = N+2 for reads, N+1 for writes, ack in the last), then one free cycle.
  int          m_j = 0;
  int          m_L = 0;
  int          m_n = 0;
  bit          m_mem, m_we, m_sgn;
  logic [31:0] m_base, m_wdata, m_rd;
  logic [31:0] e_ram_addr = '0, e_if_data = '0, e_mem_rdata = '0;
  logic [7:0]  e_ram_dout = '0;
  bit          e_ram_wr = 0, e_if_ack = 0, e_mem_ack = 0;

  function automatic int len_n(input logic [1:0] l);
    return (l == 2'b00) ? 1 : (l == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] base, input int n, input bit s);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = mdl_rd(base + 32'(k));
    if (SEXT_ON && s && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (SEXT_ON && s && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_reset();
    m_j = 0;
    e_ram_addr = '0; e_ram_dout = '0; e_ram_wr = 0;
    e_if_ack = 0; e_mem_ack = 0; e_if_data = '0; e_mem_rdata = '0;
  endtask

  task automatic model_step();
    if (e_ram_wr) mdl_mem[e_ram_addr] = e_ram_dout;
    e_ram_wr = 0; e_if_ack = 0; e_mem_ack = 0;
    if (m_j == 0) begin
      if (mem_req) begin
        m_mem = 1; m_we = mem_we; m_n = len_n(mem_len); m_base = mem_addr;
        m_wdata = mem_wdata; m_sgn = mem_signed; m_j = 1;
      end else if (if_req) begin
        m_mem = 0; m_we = 0; m_n = 4; m_base = if_addr; m_sgn = 0; m_j = 1;
      end
      if (m_j == 1) begin
        m_L = m_we ? m_n + 1 : m_n + 2;
        if (!m_we) m_rd = model_load(m_base, m_n, m_sgn);
      end
    end else if (m_j == m_L) begin
      m_j = 0;
    end else begin
      m_j++;
    end
    if (m_j > 0 && m_j <= m_n) begin
      e_ram_addr = m_base + 32'(m_j - 1);
      if (m_we) begin
        e_ram_wr = 1;
        e_ram_dout = m_wdata[8*(m_j-1) +: 8];
      end
    end
    if (m_j > 0 && m_j == m_L) begin
      if (m_mem) begin
        e_mem_ack = 1;
        if (!m_we) e_mem_rdata = m_rd;
      end else begin
        e_if_ack = 1;
        e_if_data = m_rd;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) model_reset();
    chk("ram_wr", ram_wr, e_ram_wr);
    chk("ram_addr", ram_addr, e_ram_addr);
    chk("ram_dout", ram_dout, e_ram_dout);
    chk("if_ack", if_ack, e_if_ack);
    chk("mem_ack", mem_ack, e_mem_ack);
    chk("if_data", if_data, e_if_data);
    chk("mem_rdata", mem_rdata, e_mem_rdata);
    chk("stallreq_if", stallreq_if, if_req && !e_if_ack);
    chk("stallreq_mem", stallreq_mem, mem_req && !e_mem_ack);
    if (rst) model_step();
  end

  // Directed transaction: per-cycle log indexed by offset from the accept edge.
  bit          lg_wr   [0:31];
  logic [31:0] lg_addr [0:31];
  logic [7:0]  lg_dout [0:31];

  task automatic do_req(input bit is_mem, input bit we, input logic [1:0] len, input bit sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] data);
    int cnt;
    bit done;
    @(posedge clk); #1;
    if (is_mem) begin
      mem_req = 1; mem_we = we; mem_len = len; mem_signed = sg; mem_addr = addr; mem_wdata = wd;
    end else begin
      if_req = 1; if_addr = addr;
    end
    cnt = 0; done = 0; lat = -1; data = '0;
    while (!done && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (cnt <= 32) begin
        lg_wr[cnt-1] = ram_wr; lg_addr[cnt-1] = ram_addr; lg_dout[cnt-1] = ram_dout;
      end
      if (is_mem ? mem_ack : if_ack) begin
        done = 1; lat = cnt - 1; data = is_mem ? mem_rdata : if_data;
      end
    end
    chk("req_completed", 32'(done), 32'd1);
    @(posedge clk); #1;
    if_req = 0; mem_req = 0;
  endtask

  initial begin
    int lat;
    logic [31:0] d;
    logic [31:0] wexp [0:3];
    int c_mem, c_if, c_stall, cnt;
    bit sa_if, sa_mem;

    repeat (3) @(posedge clk);
    #1 rst = 1;

    // Fetch of a known instruction word.
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
    do_req(0, 0, 2'b11, 0, 32'h100, 32'h0, lat, d);
    chk("fetch_latency", 32'(lat), 32'd6);
    chk("fetch_data", d, 32'h0000_0513);
    chk("fetch_addr0", lg_addr[1], 32'h100);
    chk("fetch_addr3", lg_addr[4], 32'h103);

    // Half-word store.
    do_req(1, 1, 2'b01, 0, 32'h200, 32'hDEAD_BEEF, lat, d);
    chk("store_latency", 32'(lat), 32'd3);
    chk("store_wr1", 32'(lg_wr[1]), 32'd1);
    chk("store_addr1", lg_addr[1], 32'h200);
    chk("store_byte1", 32'(lg_dout[1]), 32'hEF);
    chk("store_wr2", 32'(lg_wr[2]), 32'd1);
    chk("store_addr2", lg_addr[2], 32'h201);
    chk("store_byte2", 32'(lg_dout[2]), 32'hBE);
    chk("store_wr_ack", 32'(lg_wr[3]), 32'd0);

    do_req(1, 0, 2'b01, 0, 32'h200, 32'h0, lat, d);
    chk("half_load_latency", 32'(lat), 32'd4);
    chk("half_load_data", d, 32'h0000_BEEF);

    // Signed byte load.
    poke(32'h300, 8'h80);
    do_req(1, 0, 2'b00, 1, 32'h300, 32'h0, lat, d);
    chk("byte_load_latency", 32'(lat), 32'd3);
    chk("signed_byte_load", d, SEXT_ON ? 32'hFFFF_FF80 : 32'h0000_0080);

    // Word read across the top of the address space.
    do_req(1, 0, 2'b10, 0, 32'hFFFF_FFFE, 32'h0, lat, d);
    wexp[0] = 32'hFFFF_FFFE; wexp[1] = 32'hFFFF_FFFF; wexp[2] = 32'h0; wexp[3] = 32'h1;
    chk("wrap_latency", 32'(lat), 32'd6);
    for (int k = 0; k < 4; k++) chk("wrap_addr", lg_addr[k+1], wexp[k]);

    // Both requesters at once: load first, fetch after the free cycle.
    @(posedge clk); #1;
    mem_req = 1; mem_we = 0; mem_len = 2'b11; mem_signed = 0; mem_addr = 32'h40;
    if_req = 1; if_addr = 32'h80;
    c_mem = -1; c_if = -1; c_stall = 0; cnt = 0;
    while (c_if < 0 && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (stallreq_if) c_stall++;
      if (mem_ack) c_mem = cnt - 1;
      if (if_ack) c_if = cnt - 1;
      if (mem_ack) begin
        @(posedge clk); #1 mem_req = 0;
      end
    end
    @(posedge clk); #1 if_req = 0;
    chk("prio_mem_ack", 32'(c_mem), 32'd6);
    chk("prio_if_ack", 32'(c_if), 32'd13);
    chk("prio_stall_cycles", 32'(c_stall), 32'd13);

    // Reset during the second byte of a word store, then retry.
    @(posedge clk); #1;
    mem_req = 1; mem_we = 1; mem_len = 2'b11; mem_addr = 32'h400; mem_wdata = 32'h1122_3344;
    @(posedge clk);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    chk("rst_mem_ack", 32'(mem_ack), 32'd0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    @(posedge clk);
    @(posedge clk); #1 rst = 1;
    cnt = 0; lat = -1;
    while (lat < 0 && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (mem_ack) lat = cnt - 1;
    end
    chk("rst_retry_latency", 32'(lat), 32'd5);
    @(posedge clk); #1 mem_req = 0;
    do_req(1, 0, 2'b11, 0, 32'h400, 32'h0, lat, d);
    chk("rst_retry_readback", d, 32'h1122_3344);

    // Randomized traffic with occasional asynchronous resets.
    sa_if = 0; sa_mem = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      sa_if = if_ack; sa_mem = mem_ack;
      @(posedge clk); #1;
      if ($urandom_range(0, 499) == 0) begin
        rst = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        sa_if = 0; sa_mem = 0;
      end
      if (if_req && sa_if) if_req = ($urandom_range(0, 3) == 0);
      else if (!if_req) if_req = ($urandom_range(0, 2) == 0);
      if (!if_req || sa_if || $urandom_range(0, 3) == 0)
        if_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                              : {24'h0, 8'($urandom)};
      if (mem_req && sa_mem) mem_req = ($urandom_range(0, 3) == 0);
      else if (!mem_req) mem_req = ($urandom_range(0, 2) == 0);
      if (!mem_req || sa_mem || $urandom_range(0, 3) == 0) begin
        mem_we = $urandom_range(0, 1) == 1;
        mem_len = 2'($urandom);
        mem_signed = $urandom_range(0, 1) == 1;
        mem_wdata = $urandom;
        mem_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                               : {24'h0, 8'($urandom)};
      end
    end
    if_req = 0; mem_req = 0;
    repeat (10) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
